// File: rtl/pulse_tx.sv
// rtl/pulse_tx.sv - pulse-distance frame transmitter (sync burst/silence, MSB-first bits, final burst)
module pulse_tx #(
  parameter int SBD   = 1000,
  parameter int SSD   = 1000,
  parameter int BBD   = 500,
  parameter int BSD0  = 250,
  parameter int BSD1  = 500,
  parameter int WIDTH = 128
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] code_in,
  input  logic             trigger_in,
  output logic             ready_out,
  output logic             signal_out,
  output logic             done_out,
  output logic [2:0]       state_out
);

  localparam int MAX_A = (SBD > SSD) ? SBD : SSD;
  localparam int MAX_B = (BBD > BSD0) ? BBD : BSD0;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAXD  = (MAX_C > BSD1) ? MAX_C : BSD1;
  localparam int CW    = $clog2(MAXD) + 1;
  localparam int BW    = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    SYNC_BURST   = 3'd1,
    SYNC_SILENCE = 3'd2,
    BIT_BURST    = 3'd3,
    BIT_SILENCE  = 3'd4,
    FINAL_BURST  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             fin_q, fin_d;
  logic             signal_q, ready_q, done_q;
  logic             cnt_last;

  assign cnt_last = (cnt_q == CW'(1));

  // The counter holds the remaining cycles of the current state; a state
  // ends on the cycle its counter reads 1, so each lasts exactly its duration.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    fin_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger_in) begin
          sr_d    = code_in;
          cnt_d   = CW'(SBD);
          bit_d   = '0;
          state_d = SYNC_BURST;
        end
      end
      SYNC_BURST: begin
        if (cnt_last) begin
          cnt_d   = CW'(SSD);
          state_d = SYNC_SILENCE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SYNC_SILENCE: begin
        if (cnt_last) begin
          cnt_d   = CW'(BBD);
          state_d = BIT_BURST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      BIT_BURST: begin
        if (cnt_last) begin
          cnt_d   = sr_q[WIDTH-1] ? CW'(BSD1) : CW'(BSD0);
          state_d = BIT_SILENCE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      BIT_SILENCE: begin
        if (cnt_last) begin
          sr_d    = sr_q << 1;
          bit_d   = bit_q + BW'(1);
          cnt_d   = CW'(BBD);
          state_d = (bit_q == BW'(WIDTH - 1)) ? FINAL_BURST : BIT_BURST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FINAL_BURST: begin
        if (cnt_last) begin
          cnt_d   = '0;
          fin_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      fin_q   <= fin_d;
    end
  end

  // Outputs are decoded from the registered state one cycle later, so the
  // line rises the edge after acceptance and done lands with the first low cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      signal_q <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      signal_q <= (state_q == SYNC_BURST) || (state_q == BIT_BURST) ||
                  (state_q == FINAL_BURST);
      ready_q  <= (state_q == IDLE);
      done_q   <= fin_q;
    end
  end

  assign signal_out = signal_q;
  assign ready_out  = ready_q;
  assign done_out   = done_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_pulse_tx.sv
// tb/tb_pulse_tx.sv - scoreboard bench for pulse_tx with short durations and an 8-bit code
module tb_pulse_tx;

  localparam int SBD   = 10;
  localparam int SSD   = 10;
  localparam int BBD   = 5;
  localparam int BSD0  = 3;
  localparam int BSD1  = 5;
  localparam int WIDTH = 8;

  typedef struct {
    logic       sig;
    logic       done;
    logic       rdy;
    logic [2:0] st;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] code;
  logic             trig;
  logic             ready, signal, done;
  logic [2:0]       state;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pulse_tx #(
    .SBD(SBD), .SSD(SSD), .BBD(BBD), .BSD0(BSD0), .BSD1(BSD1), .WIDTH(WIDTH)
  ) dut (
    .clk_in     (clk),
    .rst_in     (rst),
    .code_in    (code),
    .trigger_in (trig),
    .ready_out  (ready),
    .signal_out (signal),
    .done_out   (done),
    .state_out  (state)
  );

  // Entry k describes the outputs sampled just after edge Ek of a frame
  // whose trigger was accepted at E0.
  task automatic expect_frame(input logic [WIDTH-1:0] c);
    logic [2:0] s[$];
    exp_t       e;
    int         f;
    repeat (SBD) s.push_back(3'd1);
    repeat (SSD) s.push_back(3'd2);
    for (int b = WIDTH - 1; b >= 0; b--) begin
      repeat (BBD) s.push_back(3'd3);
      repeat (c[b] ? BSD1 : BSD0) s.push_back(3'd4);
    end
    repeat (BBD) s.push_back(3'd5);
    f = s.size();
    s.push_back(3'd0);
    for (int k = 1; k <= f + 1; k++) begin
      e.sig  = (s[k-1] == 3'd1) || (s[k-1] == 3'd3) || (s[k-1] == 3'd5);
      e.done = (k == f + 1);
      e.rdy  = (k == f + 1);
      e.st   = (k <= f) ? s[k] : 3'd7;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_frame(input string name, input int pulse_k, input int mid_k,
                             input logic [WIDTH-1:0] mid_code, input int drop_k);
    exp_t e;
    int   k = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      k++;
      e = exp_q.pop_front();
      checks++;
      if (signal !== e.sig) begin
        errors++;
        $display("FAIL %s k=%0d signal_out got %b exp %b", name, k, signal, e.sig);
      end
      checks++;
      if (done !== e.done) begin
        errors++;
        $display("FAIL %s k=%0d done_out got %b exp %b", name, k, done, e.done);
      end
      checks++;
      if (ready !== e.rdy) begin
        errors++;
        $display("FAIL %s k=%0d ready_out got %b exp %b", name, k, ready, e.rdy);
      end
      if (e.st != 3'd7) begin
        checks++;
        if (state !== e.st) begin
          errors++;
          $display("FAIL %s k=%0d state_out got %0d exp %0d", name, k, state, e.st);
        end
      end
      if (k == pulse_k) begin
        trig = 1'b1;
        code = '1;
      end
      if (k == pulse_k + 1) trig = 1'b0;
      if (k == mid_k) code = mid_code;
      if (k == drop_k) trig = 1'b0;
    end
  endtask

  task automatic idle_check(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      checks++;
      if (signal !== 1'b0 || done !== 1'b0 || state !== 3'd0) begin
        errors++;
        $display("FAIL %s idle cycle %0d signal/done/state got %b/%b/%0d exp 0/0/0",
                 name, i, signal, done, state);
      end
    end
  endtask

  task automatic run_frame(input string name, input logic [WIDTH-1:0] c, input int pulse_k);
    code = c;
    trig = 1'b1;
    expect_frame(c);
    @(posedge clk); #1;
    trig = 1'b0;
    check_frame(name, pulse_k, -1, '0, -1);
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    trig = 1'b0;
    code = '0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    checks++;
    if (signal !== 1'b0) begin
      errors++; $display("FAIL reset signal_out got %b exp 0", signal);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset done_out got %b exp 0", done);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL reset ready_out got %b exp 1", ready);
    end
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL reset state_out got %0d exp 0", state);
    end
    rst = 1'b0;
    idle_check("idle", 100);
  endtask

  task automatic test_short_frame;
    run_frame("short_ba", 8'hBA, -1);
    idle_check("short_after", 5);
  endtask

  task automatic test_ignore_busy;
    // trigger with a different code arrives at E30 and must change nothing
    run_frame("busy_ba", 8'hBA, 29);
    idle_check("busy_after", 10);
  endtask

  task automatic test_patterns;
    run_frame("all_zero", 8'h00, -1);
    idle_check("zero_after", 3);
    run_frame("all_one", 8'hFF, -1);
    idle_check("one_after", 3);
    run_frame("lsb_only", 8'h01, -1);
    idle_check("lsb_after", 3);
  endtask

  task automatic test_back_to_back;
    code = 8'hBA;
    trig = 1'b1;
    expect_frame(8'hBA);
    @(posedge clk); #1;
    check_frame("b2b_first", -1, 50, 8'h3C, -1);
    expect_frame(8'h3C);
    check_frame("b2b_second", -1, -1, '0, 1);
    idle_check("b2b_after", 20);
  endtask

  task automatic test_reset_mid;
    int n = 0;
    code = 8'hBA;
    trig = 1'b1;
    @(posedge clk); #1;
    trig = 1'b0;
    while (state !== 3'd4 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL mid_reset wait for BIT_SILENCE got state %0d exp 4", state);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (signal !== 1'b0 || state !== 3'd0 || done !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset signal/state/done/ready got %b/%0d/%b/%b exp 0/0/0/1",
               signal, state, done, ready);
    end
    rst = 1'b0;
    idle_check("mid_reset_after", 120);
    run_frame("post_reset", 8'h5A, -1);
    idle_check("post_reset_after", 3);
  endtask

  initial begin
    test_reset();
    test_short_frame();
    test_ignore_busy();
    test_patterns();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
